btn_conditioner_array: RTL and testbench

N-channel push-button/switch input conditioner. It is the parametrised successor to the per-button debounce_onepulse instances in the FPGA top wrappers. Each channel provides a 2-FF synchroniser, counter-based debounce, press/release one-pulses, long-press detection and sticky press flags with write-1-to-clear. It sits between board buttons and processor control inputs (add, jump, advance, dest bits), and one instance replaces all per-button debouncers.

---
 rtl/btn_conditioner_array.sv | 124 ++++++++++++
 tb/tb_btn_conditioner_array.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner_array.sv
// btn_conditioner_array: N-channel 2-FF sync, debounce, press/release/long one-pulses, sticky W1C press flags.
// Define AUTO_REPEAT_EN to generate per-channel auto-repeat pulses after a long press.
module btn_conditioner_array #(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int HOLD_CYCLES     = 32,
    parameter int REPEAT_PERIOD   = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_in,
    input  logic [N_CH-1:0] clr_flag,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] long_pulse,
    output logic [N_CH-1:0] repeat_pulse,
    output logic [N_CH-1:0] press_flag,
    output logic            any_press
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] H_MAX  = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);

    if (N_CH < 1 || DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("btn_conditioner_array: all parameters must be >= 1");
    end

    logic [N_CH-1:0] s1_q, s1_d, s2_q, s2_d, level_q, level_d, press_q, press_d;
    logic [N_CH-1:0] release_q, release_d, long_q, long_d, flag_q, flag_d, done;
    logic [N_CH-1:0][DW-1:0] dcnt_q, dcnt_d;
    logic [N_CH-1:0][HW-1:0] hcnt_q, hcnt_d;
    logic any_q, any_d;

    always_comb begin
        s1_d = btn_in;
        s2_d = s1_q;
        done = '0;
        level_d = level_q;
        press_d = '0;
        release_d = '0;
        long_d = '0;
        flag_d = flag_q;
        dcnt_d = dcnt_q;
        hcnt_d = hcnt_q;
        for (int i = 0; i < N_CH; i++) begin
            done[i] = s2_q[i] != level_q[i] && dcnt_q[i] == D_LAST;
            dcnt_d[i] = (s2_q[i] == level_q[i] || done[i]) ? '0 : dcnt_q[i] + 1'b1;
            level_d[i] = done[i] ? s2_q[i] : level_q[i];
            press_d[i] = done[i] && s2_q[i];
            release_d[i] = done[i] && !s2_q[i];
            // level_q is still 0 on the press edge, so this also clears the count there
            hcnt_d[i] = !level_q[i] ? '0 : hcnt_q[i] == H_MAX ? H_MAX : hcnt_q[i] + 1'b1;
            long_d[i] = level_q[i] && level_d[i] && hcnt_q[i] == H_LAST;
            flag_d[i] = press_q[i] || (flag_q[i] && !clr_flag[i]);
        end
        any_d = |press_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
            level_q <= '0;
            press_q <= '0;
            release_q <= '0;
            long_q <= '0;
            flag_q <= '0;
            dcnt_q <= '0;
            hcnt_q <= '0;
            any_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            level_q <= level_d;
            press_q <= press_d;
            release_q <= release_d;
            long_q <= long_d;
            flag_q <= flag_d;
            dcnt_q <= dcnt_d;
            hcnt_q <= hcnt_d;
            any_q <= any_d;
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_PERIOD + 1);
    localparam logic [RW-1:0] R_LAST = RW'(REPEAT_PERIOD - 1);
    logic [N_CH-1:0][RW-1:0] rcnt_q, rcnt_d;
    logic [N_CH-1:0] rep_q, rep_d;

    always_comb begin
        rep_d = '0;
        rcnt_d = rcnt_q;
        for (int i = 0; i < N_CH; i++) begin
            rep_d[i] = long_d[i] || (level_q[i] && level_d[i] && hcnt_q[i] == H_MAX && rcnt_q[i] == R_LAST);
            rcnt_d[i] = (!level_d[i] || rep_d[i] || hcnt_q[i] != H_MAX) ? '0 : rcnt_q[i] + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_q <= '0;
            rcnt_q <= '0;
        end else begin
            rep_q <= rep_d;
            rcnt_q <= rcnt_d;
        end
    end

    assign repeat_pulse = rep_q;
`else
    assign repeat_pulse = '0;
`endif

    assign level = level_q;
    assign press_pulse = press_q;
    assign release_pulse = release_q;
    assign long_pulse = long_q;
    assign press_flag = flag_q;
    assign any_press = any_q;
endmodule

// File: tb/tb_btn_conditioner_array.sv
// tb_btn_conditioner_array: directed vector table plus hand-written multi-cycle sequences.
module tb_btn_conditioner_array;
    localparam int N = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] btn_in = '0;
    logic [N-1:0] clr_flag = '0;
    logic [N-1:0] level, press_pulse, release_pulse, long_pulse, repeat_pulse, press_flag;
    logic any_press;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    btn_conditioner_array #(
        .N_CH(N), .DEBOUNCE_CYCLES(8), .HOLD_CYCLES(32), .REPEAT_PERIOD(16)
    ) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in), .clr_flag(clr_flag),
        .level(level), .press_pulse(press_pulse), .release_pulse(release_pulse),
        .long_pulse(long_pulse), .repeat_pulse(repeat_pulse), .press_flag(press_flag),
        .any_press(any_press)
    );

    typedef struct {
        logic       r;
        logic [3:0] btn, clr, lvl, prs, rel, flg;
        logic       any;
    } vec_t;
    vec_t tv[15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic pick(input int sel, input int ch);
        return sel == 0 ? press_pulse[ch] : sel == 1 ? release_pulse[ch] :
               sel == 2 ? long_pulse[ch] : repeat_pulse[ch];
    endfunction

    // n = ticks until the selected pulse is seen, or -1 if the budget runs out
    task automatic wait_evt(input int sel, input int ch, input int max, output int n);
        n = -1;
        for (int k = 1; k <= max; k++) begin
            tick();
            if (pick(sel, ch)) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n, cnt;
        int rep_n;
        int rep_off[8];
        int exp_off[4];

        tv[0] = '{1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
        tv[1] = '{1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
        for (int i = 2; i <= 10; i++) tv[i] = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
        tv[11] = '{1'b0, 4'hF, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 1'b1};
        tv[12] = '{1'b0, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 1'b0};
        tv[13] = '{1'b0, 4'hF, 4'h1, 4'hF, 4'h0, 4'h0, 4'hE, 1'b0};
        tv[14] = '{1'b0, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hE, 1'b0};

        // 1: reset with all buttons held, then re-detection at edge 9
        for (int i = 0; i < 15; i++) begin
            rst = tv[i].r;
            btn_in = tv[i].btn;
            clr_flag = tv[i].clr;
            tick();
            chk($sformatf("v%0d level", i), level, tv[i].lvl);
            chk($sformatf("v%0d press", i), press_pulse, tv[i].prs);
            chk($sformatf("v%0d release", i), release_pulse, tv[i].rel);
            chk($sformatf("v%0d flag", i), press_flag, tv[i].flg);
            chk($sformatf("v%0d any", i), any_press, tv[i].any);
            if (i < 2) chk($sformatf("v%0d long_rep", i), {long_pulse, repeat_pulse}, 8'h00);
        end
        btn_in = '0;
        wait_evt(1, 0, 12, n);
        chk("all release latency", n, 10);
        chk("all release pulse", release_pulse, 4'hF);
        clr_flag = 4'hF;
        tick();
        clr_flag = '0;
        chk("flags cleared", press_flag, 4'h0);

        // 2: short glitch rejected, then a real press
        btn_in[0] = 1'b1;
        repeat (5) tick();
        btn_in[0] = 1'b0;
        cnt = 0;
        repeat (15) begin
            tick();
            cnt += int'(level[0] | press_pulse[0] | press_flag[0]);
        end
        chk("glitch ignored", cnt, 0);
        btn_in[0] = 1'b1;
        wait_evt(0, 0, 20, n);
        chk("ch0 press latency", n, 10);
        cnt = 0;
        repeat (10) begin
            tick();
            cnt += int'(press_pulse[0]);
        end
        chk("ch0 single press", cnt, 0);
        btn_in[0] = 1'b0;
        wait_evt(1, 0, 12, n);
        chk("ch0 release latency", n, 10);

        // 3: long press on ch1, then a short hold with no long pulse
        btn_in[1] = 1'b1;
        wait_evt(0, 1, 12, n);
        chk("ch1 press latency", n, 10);
        wait_evt(2, 1, 40, n);
        chk("ch1 long delay", n, 32);
        cnt = 0;
        repeat (8) begin
            tick();
            cnt += int'(long_pulse[1]);
        end
        chk("ch1 one long", cnt, 0);
        btn_in[1] = 1'b0;
        wait_evt(1, 1, 12, n);
        chk("ch1 release latency", n, 10);
        btn_in[1] = 1'b1;
        cnt = 0;
        repeat (20) begin
            tick();
            cnt += int'(long_pulse[1]);
        end
        btn_in[1] = 1'b0;
        repeat (15) begin
            tick();
            cnt += int'(long_pulse[1]);
        end
        chk("ch1 short no long", cnt, 0);
        chk("ch1 level low", level[1], 1'b0);

        // 4: set beats clear; clear while held stays clear
        clr_flag = 4'hF;
        tick();
        clr_flag = '0;
        btn_in[2] = 1'b1;
        wait_evt(0, 2, 12, n);
        chk("ch2 press latency", n, 10);
        clr_flag[2] = 1'b1;
        tick();
        clr_flag[2] = 1'b0;
        chk("ch2 set wins", press_flag[2], 1'b1);
        tick();
        chk("ch2 flag sticky", press_flag[2], 1'b1);
        clr_flag[2] = 1'b1;
        tick();
        clr_flag[2] = 1'b0;
        chk("ch2 cleared", press_flag[2], 1'b0);
        repeat (5) tick();
        chk("ch2 stays clear", {level[2], press_flag[2]}, 2'b10);
        btn_in[2] = 1'b0;
        wait_evt(1, 2, 12, n);
        chk("ch2 release latency", n, 10);

        // 5: auto-repeat on ch3, held 80 cycles past press
        btn_in[3] = 1'b1;
        wait_evt(0, 3, 12, n);
        chk("ch3 press latency", n, 10);
        rep_n = 0;
        for (int k = 1; k <= 110; k++) begin
            if (k == 81) btn_in[3] = 1'b0;
            tick();
            if (repeat_pulse[3]) begin
                if (rep_n < 8) rep_off[rep_n] = k;
                rep_n++;
            end
        end
        chk("ch3 level low", level[3], 1'b0);
`ifdef AUTO_REPEAT_EN
        exp_off = '{32, 48, 64, 80};
        chk("ch3 repeat count", rep_n, 4);
        for (int j = 0; j < 4 && j < rep_n; j++) chk($sformatf("ch3 repeat %0d", j), rep_off[j], exp_off[j]);
`else
        chk("ch3 repeat absent", rep_n, 0);
`endif

        // 6: simultaneous presses on ch0 and ch2
        btn_in = 4'b0101;
        wait_evt(0, 0, 12, n);
        chk("dual press latency", n, 10);
        chk("dual press pulses", press_pulse, 4'b0101);
        chk("dual any", any_press, 1'b1);
        cnt = 1;
        repeat (5) begin
            tick();
            cnt += int'(any_press);
        end
        chk("any one cycle", cnt, 1);
        chk("dual level", level, 4'b0101);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
